// File: rtl/chip_tx_pkg.sv
// Shared constants and helpers for the chip-to-chip transmit arbiter.
package chip_tx_pkg;

  localparam int DROP_W = 16;
  localparam logic [DROP_W-1:0] DROP_SAT = 16'hFFFF;

  function automatic int log2c(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/chip_tx_port_fifo.sv
// Per-link synchronous FIFO. Pushes while full are ignored, so the caller can
// treat push & full as a dropped word.
module chip_tx_port_fifo
  import chip_tx_pkg::*;
#(
  parameter int FW    = 64,
  parameter int DEPTH = 4,
  localparam int AW   = log2c(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [FW-1:0] din,
  output logic [FW-1:0] dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [FW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Full/empty come from the count held at the start of the cycle.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/chip_tx_arbiter.sv
// Round-robin merge of CONNECT link FIFOs into one {index, payload} stream.
// Optional per-link drop counters are built when CHIP_TX_ARB_STATS_EN is defined.
module chip_tx_arbiter
  import chip_tx_pkg::*;
#(
  parameter int FW      = 64,
  parameter int CONNECT = 2,
  parameter int DEPTH   = 4,
  localparam int IW     = (log2c(CONNECT) < 1) ? 1 : log2c(CONNECT),
  localparam int CW     = log2c(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arb_en,
  input  logic [CONNECT-1:0]        port_wr,
  input  logic [CONNECT*FW-1:0]     port_data,
  output logic [CONNECT-1:0]        port_full,
  output logic                      data_out_wr,
  output logic [FW+IW-1:0]          data_out,
  input  logic                      send_fifo_full,
  output logic [CONNECT*DROP_W-1:0] drop_cnt
);

  logic [CONNECT-1:0] fifo_full;
  logic [CONNECT-1:0] fifo_empty;
  logic [CONNECT-1:0] pop;
  logic [FW-1:0]      fifo_dout  [CONNECT];
  logic [CW-1:0]      fifo_count [CONNECT];
  logic               grant;
  logic               found;
  logic [IW-1:0]      winner;
  logic [IW-1:0]      last;

  for (genvar g = 0; g < CONNECT; g++) begin : g_port
    chip_tx_port_fifo #(
      .FW    (FW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (port_wr[g]),
      .pop   (pop[g]),
      .din   (port_data[g*FW +: FW]),
      .dout  (fifo_dout[g]),
      .count (fifo_count[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g])
    );
  end

  assign port_full = fifo_full;

  // Search starts just after the last winner and wraps, so a busy link never starves.
  always_comb begin
    logic [IW-1:0] cand;
    found  = 1'b0;
    winner = last;
    cand   = last;
    for (int k = 0; k < CONNECT; k++) begin
      cand = (cand == IW'(CONNECT-1)) ? '0 : cand + 1'b1;
      if (!found && !fifo_empty[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    grant = found & arb_en & ~send_fifo_full;
  end

  always_comb begin
    pop = '0;
    if (grant) pop[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_wr <= 1'b0;
      data_out    <= '0;
      last        <= IW'(CONNECT-1);
    end else begin
      data_out_wr <= grant;
      if (grant) begin
        data_out <= {winner, fifo_dout[winner]};
        last     <= winner;
      end
    end
  end

`ifdef CHIP_TX_ARB_STATS_EN
  for (genvar g = 0; g < CONNECT; g++) begin : g_stats
    logic [DROP_W-1:0] cnt;

    // A write is dropped when the link FIFO was already full at the start of the cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (port_wr[g] && fifo_full[g] && (cnt != DROP_SAT)) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign drop_cnt[g*DROP_W +: DROP_W] = cnt;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_chip_tx_arbiter.sv
// Directed self-checking bench for chip_tx_arbiter with an ordered word scoreboard.
module tb_chip_tx_arbiter;

  localparam int FW      = 64;
  localparam int CONNECT = 2;
  localparam int DEPTH   = 4;

`ifdef CHIP_TX_ARB_STATS_EN
  localparam int DROP1_EXP = 2;
  localparam int DROP0_EXP = 1;
`else
  localparam int DROP1_EXP = 0;
  localparam int DROP0_EXP = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  arb_en;
  logic [CONNECT-1:0]    port_wr;
  logic [CONNECT*FW-1:0] port_data;
  logic [CONNECT-1:0]    port_full;
  logic                  data_out_wr;
  logic [FW:0]           data_out;
  logic                  send_fifo_full;
  logic [CONNECT*16-1:0] drop_cnt;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int p0;
  logic [FW:0] exp_q [$];

  always #5 clk = ~clk;

  chip_tx_arbiter #(
    .FW      (FW),
    .CONNECT (CONNECT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .arb_en         (arb_en),
    .port_wr        (port_wr),
    .port_data      (port_data),
    .port_full      (port_full),
    .data_out_wr    (data_out_wr),
    .data_out       (data_out),
    .send_fifo_full (send_fifo_full),
    .drop_cnt       (drop_cnt)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] wr, input logic [63:0] d0, input logic [63:0] d1);
    port_wr   = wr;
    port_data = {d1, d0};
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Every issued word must be the oldest outstanding expected word.
  always @(negedge clk) begin
    if (data_out_wr === 1'b1) begin
      pulses++;
      checkOutput("sb_has_entry", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) checkOutput("sb_word", 128'(data_out), 128'(exp_q.pop_front()));
    end
  end

  initial begin
    rst            = 1'b1;
    arb_en         = 1'b1;
    send_fifo_full = 1'b0;
    applyStimulus(2'b11, 64'hDEAD_0000_0000_0001, 64'hDEAD_0000_0000_0002);
    step(3);
    rst = 1'b0;
    applyStimulus(2'b00, 64'h0, 64'h0);
    checkOutput("rst_data_out_wr", 128'(data_out_wr), 128'd0);
    checkOutput("rst_data_out", 128'(data_out), 128'd0);
    checkOutput("rst_port_full", 128'(port_full), 128'd0);
    checkOutput("rst_drop_cnt", 128'(drop_cnt), 128'd0);
    step(1);
    checkOutput("rst_fifos_empty", 128'(data_out_wr), 128'd0);

    // Fairness: both links stream three words, expect strict alternation from link 0.
    p0 = pulses;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b11, 64'hA0 + 64'(k), 64'hB0 + 64'(k));
      exp_q.push_back({1'b0, 64'hA0 + 64'(k)});
      exp_q.push_back({1'b1, 64'hB0 + 64'(k)});
      step(1);
    end
    applyStimulus(2'b00, 64'h0, 64'h0);
    step(4);
    checkOutput("fair_last_pulse", 128'(data_out_wr), 128'd1);
    step(1);
    checkOutput("fair_idle_after", 128'(data_out_wr), 128'd0);
    checkOutput("fair_pulse_count", 128'(pulses - p0), 128'd6);

    // Single word: two-edge latency from write to data_out_wr.
    applyStimulus(2'b01, 64'h0123_4567_89AB_CDEF, 64'h0);
    exp_q.push_back({1'b0, 64'h0123_4567_89AB_CDEF});
    step(1);
    applyStimulus(2'b00, 64'h0, 64'h0);
    checkOutput("single_not_early", 128'(data_out_wr), 128'd0);
    step(1);
    checkOutput("single_wr", 128'(data_out_wr), 128'd1);
    checkOutput("single_data", 128'(data_out), 128'({1'b0, 64'h0123_4567_89AB_CDEF}));
    step(1);
    checkOutput("single_one_pulse", 128'(data_out_wr), 128'd0);

    // Backpressure: last grant was link 0, so link 1 goes first on release.
    arb_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b11, 64'hC0 + 64'(k), 64'hD0 + 64'(k));
      exp_q.push_back({1'b1, 64'hD0 + 64'(k)});
      exp_q.push_back({1'b0, 64'hC0 + 64'(k)});
      step(1);
    end
    applyStimulus(2'b00, 64'h0, 64'h0);
    send_fifo_full = 1'b1;
    arb_en         = 1'b1;
    p0             = pulses;
    for (int k = 0; k < 5; k++) begin
      step(1);
      checkOutput($sformatf("bp_hold_%0d", k), 128'(data_out_wr), 128'd0);
    end
    send_fifo_full = 1'b0;
    step(1);
    checkOutput("bp_resume", 128'(data_out_wr), 128'd1);
    step(5);
    checkOutput("bp_sixth", 128'(data_out_wr), 128'd1);
    step(1);
    checkOutput("bp_done", 128'(data_out_wr), 128'd0);
    checkOutput("bp_pulse_count", 128'(pulses - p0), 128'd6);

    // Overflow on link 1 with the arbiter disabled.
    arb_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'b10, 64'h0, 64'hE0 + 64'(k));
      if (k < 4) exp_q.push_back({1'b1, 64'hE0 + 64'(k)});
      step(1);
      checkOutput($sformatf("ovf_full_%0d", k), 128'(port_full[1]), 128'(k >= 3));
    end
    applyStimulus(2'b00, 64'h0, 64'h0);
    checkOutput("ovf_drop1", 128'(drop_cnt[31:16]), 128'(DROP1_EXP));
    checkOutput("ovf_drop0", 128'(drop_cnt[15:0]), 128'd0);
    arb_en = 1'b1;
    p0     = pulses;
    step(1);
    checkOutput("ovf_full_falls", 128'(port_full[1]), 128'd0);
    step(4);
    checkOutput("ovf_drain_count", 128'(pulses - p0), 128'd4);
    checkOutput("ovf_sb_empty", 128'(exp_q.size()), 128'd0);

    // Simultaneous push and pop at count 3 on link 0.
    arb_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b01, 64'hF0 + 64'(k), 64'h0);
      exp_q.push_back({1'b0, 64'hF0 + 64'(k)});
      step(1);
    end
    applyStimulus(2'b01, 64'hF3, 64'h0);
    exp_q.push_back({1'b0, 64'hF3});
    arb_en = 1'b1;
    step(1);
    checkOutput("pp_not_full", 128'(port_full[0]), 128'd0);
    arb_en = 1'b0;
    applyStimulus(2'b01, 64'hF4, 64'h0);
    exp_q.push_back({1'b0, 64'hF4});
    step(1);
    checkOutput("pp_full_after_one", 128'(port_full[0]), 128'd1);
    applyStimulus(2'b01, 64'hF5, 64'h0);
    step(1);
    applyStimulus(2'b00, 64'h0, 64'h0);
    checkOutput("pp_drop0", 128'(drop_cnt[15:0]), 128'(DROP0_EXP));
    checkOutput("pp_drop1_held", 128'(drop_cnt[31:16]), 128'(DROP1_EXP));
    arb_en = 1'b1;
    step(5);
    checkOutput("pp_sb_empty", 128'(exp_q.size()), 128'd0);

    // Mid-stream reset with both FIFOs loaded.
    arb_en = 1'b0;
    applyStimulus(2'b11, 64'h55, 64'h66);
    step(2);
    rst = 1'b1;
    step(3);
    exp_q.delete();
    rst = 1'b0;
    applyStimulus(2'b00, 64'h0, 64'h0);
    arb_en = 1'b1;
    checkOutput("mid_rst_data_out_wr", 128'(data_out_wr), 128'd0);
    checkOutput("mid_rst_data_out", 128'(data_out), 128'd0);
    checkOutput("mid_rst_port_full", 128'(port_full), 128'd0);
    checkOutput("mid_rst_drop_cnt", 128'(drop_cnt), 128'd0);
    step(1);
    checkOutput("mid_rst_emptied", 128'(data_out_wr), 128'd0);
    applyStimulus(2'b11, 64'h1111, 64'h2222);
    exp_q.push_back({1'b0, 64'h1111});
    exp_q.push_back({1'b1, 64'h2222});
    step(1);
    applyStimulus(2'b00, 64'h0, 64'h0);
    step(1);
    checkOutput("mid_rst_first_link0", 128'(data_out), 128'({1'b0, 64'h1111}));
    step(1);
    checkOutput("mid_rst_then_link1", 128'(data_out), 128'({1'b1, 64'h2222}));

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
    checkOutput("sb_drained", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chip_tx_arbiter.md
# chip_tx_arbiter

Merges traffic from CONNECT local links into the single tagged word stream that feeds the chip-to-chip interface's send FIFO (its `data_out` / `data_out_wr` inputs). Each link gets a small private FIFO. A round-robin arbiter drains one word per cycle, prepends the link index, and honours the downstream almost-full (`send_fifo_full`).

## Interface
Parameters:
- FW, 64, payload width per word.
- CONNECT, 2, number of local links (≥2).
- DEPTH, 4, per-link FIFO depth in words (power of two, ≥2).
- IW, derived = log2(CONNECT), index field width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- arb_en  in  1  grant enable; when low, no words are issued.
- port_wr  in  CONNECT  per-link write strobe.
- port_data  in  CONNECT*FW  link i occupies [i*FW +: FW].
- port_full  out  CONNECT  link i FIFO holds DEPTH words.
- data_out_wr  out  1  one-cycle pulse per issued word.
- data_out  out  FW+IW  {index, payload}; index in [FW+IW-1:FW].
- send_fifo_full  in  1  downstream almost-full.
- drop_cnt  out  CONNECT*16  per-link dropped-word counters, link i at [i*16 +: 16].

## Operation
- Write: `port_wr[i]` with `port_full[i]` low pushes `port_data[i]` into FIFO i. With `port_full[i]` high, the word is dropped.
- A write while full is dropped even if a read of the same FIFO occurs in that cycle. `port_full` is computed from the count at the start of the cycle.
- Grant condition, evaluated each cycle: `arb_en` is high, `send_fifo_full` is low, and at least one FIFO is non-empty.
- Round-robin pointer `last` holds the last granted index. The search starts at `last+1` and wraps modulo CONNECT. The first non-empty FIFO wins.
- On a grant:
  - The winning FIFO pops one word.
  - `data_out` is registered as {winner index, word}.
  - `data_out_wr` is registered as 1.
  - `last` updates to the winner.
- No grant: `data_out_wr` is registered as 0, `data_out` holds its previous value, and `last` is unchanged.
- A link with continuous traffic never starves. With all links busy, grants rotate 0,1,…,CONNECT-1.
- FIFO count range is 0..DEPTH, so the count width is log2(DEPTH)+1. Read and write pointers are log2(DEPTH) bits and wrap naturally.
- A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Reset, including mid-stream: all FIFOs are emptied (pointers and counts = 0), `last` = CONNECT-1 so link 0 is served first, and `drop_cnt` is cleared. In-flight words are discarded.

## Timing
Reset values: `data_out_wr`=0, `data_out`=0, `port_full`=0, `drop_cnt`=0.

Latency:
- A word written at edge N appears with `data_out_wr`=1 in cycle N+2 when the link is uncontended and not backpressured.
- Throughput is one word per cycle across all links.

Backpressure:
- `send_fifo_full` is sampled in the grant cycle.
- While it is high, no grant is made. `data_out_wr` goes low on the following cycle.
- One word registered in the cycle before the assertion can still emerge; the downstream almost-full margin absorbs it.
- After deassertion in cycle M, the first `data_out_wr` occurs in M+1.

`port_full[i]` rises in the cycle after the DEPTH-th accepted write. It falls in the cycle after the first pop.

## Configuration
- `CHIP_TX_ARB_STATS_EN` defined:
  - Each dropped write increments `drop_cnt[i]` by 1.
  - Counters saturate at 16'hFFFF.
  - Simultaneous drops on several links each count.
- Not defined: no counter logic is built and `drop_cnt` is tied to 0. Ports are unchanged.

## Structure
- Package `chip_tx_pkg`:
  - the log2 function
  - the drop-counter width constant (16)
  - the counter saturation value
- Sub-module `chip_tx_port_fifo`:
  - synchronous FIFO, width FW, depth DEPTH
  - push, pop, dout, count, full, empty
  - instantiated CONNECT times
- Arbiter, pointer, output register and counters live in the top module.

## Test plan
- Reset: hold rst 3 cycles during traffic. Required: next cycle all outputs 0, `port_full`=0; first later grant goes to link 0.
- Single word: `port_wr[0]` with 64'h0123_4567_89AB_CDEF at edge 1. Required: `data_out_wr`=1 only in cycle 3, `data_out`={1'b0, 64'h0123_4567_89AB_CDEF}.
- Fairness: links 0 and 1 each write 3 words back-to-back. Required: outputs are six consecutive pulses with indices 0,1,0,1,0,1 and per-link order preserved.
- Backpressure: `send_fifo_full` high for 5 cycles with both FIFOs loaded. Required: no new grants in that window; after release, resumption in the next cycle with no loss or duplication.
- Overflow: DEPTH=4, `arb_en`=0, 6 writes to link 1. Required: `port_full[1]`=1 after 4 writes. `drop_cnt[1]`=2 with `CHIP_TX_ARB_STATS_EN`, 0 without. After `arb_en`=1, exactly 4 words emerge, in order.
- Push and pop same cycle at count 3 on link 0: count stays 3 and `port_full[0]` stays 0.
